dlx_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the DLX datapath. It consumes the per-instruction control signals produced by the opcode decoder and steps the shared datapath through fetch, decode, execute, memory and writeback phases. It handshakes with instruction and data memory, and generates all register, PC and memory enables. It sits between the decoder and the datapath registers (PC, IR, register file).

---
 rtl/dlx_seq_pkg.sv | 27 ++
 rtl/dlx_seq_perf.sv | 29 ++
 rtl/dlx_sequencer.sv | 128 ++++++++++++
 tb/tb_dlx_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_seq_pkg.sv
// Shared types and constants for the DLX multi-cycle sequencer.
// State encoding, next-PC select codes and the branch decision helper.
package dlx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_J   = 2'd2;
  localparam logic [1:0] PC_SEL_JR  = 2'd3;

  function automatic logic br_taken(
    input logic bz,
    input logic bnz,
    input logic zero
  );
    return (bz & zero) | (bnz & ~zero);
  endfunction

endpackage

// File: rtl/dlx_seq_perf.sv
// Performance counters for the DLX sequencer.
// Counts busy cycles and retired instructions (pc_we pulses), wrapping.
module dlx_seq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_busy,
  input  logic        i_pc_we,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instr_cnt
);

  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Free-running counters gated by activity; natural 32-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (i_busy)  r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (i_pc_we) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;

endmodule

// File: rtl/dlx_sequencer.sv
// Multi-cycle DLX sequencer: fetch/decode/exec/mem/wb control.
// Optional perf counters when DLX_SEQ_PERF_EN is defined.
module dlx_sequencer
  import dlx_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        mem_wr,
  input  logic        reg_wr,
  input  logic        mem_to_reg,
  input  logic        branch_z,
  input  logic        branch_nz,
  input  logic        jmp,
  input  logic        jmp_r,
  input  logic        link,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
`ifdef DLX_SEQ_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  output logic        busy,
  output logic [2:0]  state
);

  state_e r_state;
  state_e w_next;
  state_e w_end_next;

  // Where control goes when an instruction completes.
  assign w_end_next = run ? ST_FETCH : ST_IDLE;

  // State register; async reset kills any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and control outputs from state plus live inputs.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    unique case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (branch_z | branch_nz) begin
          pc_we  = 1'b1;
          pc_sel = br_taken(branch_z, branch_nz, zero)
                 ? PC_SEL_BR : PC_SEL_SEQ;
          w_next = w_end_next;
        end else if ((jmp | jmp_r) & ~link) begin
          pc_we  = 1'b1;
          pc_sel = jmp ? PC_SEL_J : PC_SEL_JR;
          w_next = w_end_next;
        end else if (mem_wr | mem_to_reg) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_wr;
        if (dmem_ready) begin
          if (mem_wr) begin
            pc_we  = 1'b1;
            w_next = w_end_next;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we  = reg_wr | link;
        pc_we  = 1'b1;
        if (link & jmp)        pc_sel = PC_SEL_J;
        else if (link & jmp_r) pc_sel = PC_SEL_JR;
        else                   pc_sel = PC_SEL_SEQ;
        w_next = w_end_next;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign state = r_state;

`ifdef DLX_SEQ_PERF_EN
  dlx_seq_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_busy      (busy),
    .i_pc_we     (pc_we),
    .o_cycle_cnt (cycle_cnt),
    .o_instr_cnt (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_dlx_sequencer.sv
// Self-checking bench for dlx_sequencer.
// Table-driven single instructions plus hand-written corner sequences.
module tb_dlx_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       mem_wr, reg_wr, mem_to_reg;
  logic       branch_z, branch_nz, jmp, jmp_r, link, zero;
  logic       imem_ready, dmem_ready;
  logic       imem_req, ir_we, dmem_req, dmem_we;
  logic       rf_we, pc_we, busy;
  logic [1:0] pc_sel;
  logic [2:0] state;
`ifdef DLX_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  dlx_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_wr     (mem_wr),
    .reg_wr     (reg_wr),
    .mem_to_reg (mem_to_reg),
    .branch_z   (branch_z),
    .branch_nz  (branch_nz),
    .jmp        (jmp),
    .jmp_r      (jmp_r),
    .link       (link),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
`ifdef DLX_SEQ_PERF_EN
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
`endif
    .busy       (busy),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  mw, rw, m2r, bz, bnz, j, jr, lk, z;
    int    iwait, dwait;
    int    e_cyc, e_sel, e_rf, e_dreq, e_dwe;
  } vec_t;

  vec_t vt[14];
  int   st_log[16];
  int   st_n;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_dec(input vec_t v);
    mem_wr = v.mw; reg_wr = v.rw; mem_to_reg = v.m2r;
    branch_z = v.bz; branch_nz = v.bnz;
    jmp = v.j; jmp_r = v.jr; link = v.lk; zero = v.z;
  endtask

  function automatic vec_t mk(
    input string nm,
    input logic mw, rw, m2r, bz, bnz, j, jr, lk, z,
    input int iw, dw, cyc, sel, rf, dq, dwe
  );
    vec_t v;
    v.name = nm; v.mw = mw; v.rw = rw; v.m2r = m2r;
    v.bz = bz; v.bnz = bnz; v.j = j; v.jr = jr; v.lk = lk; v.z = z;
    v.iwait = iw; v.dwait = dw;
    v.e_cyc = cyc; v.e_sel = sel; v.e_rf = rf;
    v.e_dreq = dq; v.e_dwe = dwe;
    return v;
  endfunction

  // Runs one instruction from IDLE; drops run when pc_we is seen.
  task automatic run_vec(input vec_t v);
    int cyc, pcw, sel, rf, dq, dwe, irw, fk, dk;
    bit done;
    cyc = 0; pcw = 0; sel = -1; rf = 0;
    dq = 0; dwe = 0; irw = 0; fk = 0; dk = 0;
    done = 0; st_n = 0;
    set_dec(v);
    run = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      imem_ready = (state == 3'd1) && (fk == v.iwait);
      dmem_ready = (state == 3'd4) && (dk == v.dwait);
      #1;
      if (st_n < 16) begin
        st_log[st_n] = int'(state);
        st_n++;
      end
      if (busy) cyc++;
      if (state == 3'd1) fk++;
      if (state == 3'd4) dk++;
      if (ir_we) irw++;
      if (rf_we) rf++;
      if (dmem_req) dq++;
      if (dmem_req && dmem_we) dwe++;
      if (pc_we) begin
        pcw++;
        sel = int'(pc_sel);
        run = 1'b0;
        done = 1;
      end
    end
    chk({v.name, " done"}, int'(done), 1);
    chk({v.name, " cycles"}, cyc, v.e_cyc);
    chk({v.name, " pc_we"}, pcw, 1);
    chk({v.name, " pc_sel"}, sel, v.e_sel);
    chk({v.name, " rf_we"}, rf, v.e_rf);
    chk({v.name, " dmem_req"}, dq, v.e_dreq);
    chk({v.name, " dmem_we"}, dwe, v.e_dwe);
    chk({v.name, " ir_we"}, irw, 1);
    @(negedge clk);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk({v.name, " idle after"}, int'(state), 0);
  endtask

  // Back-to-back ADDIs with run held high until the n-th retires.
  task automatic run_addi(input int n, output int cyc, output int pcw);
    vec_t v;
    v = mk("ADDIx", 0,1,0,0,0,0,0,0,0, 0,0, 0,0,0,0,0);
    set_dec(v);
    cyc = 0; pcw = 0;
    run = 1'b1;
    imem_ready = 1'b1;
    for (int c = 0; c < 8 * n + 10 && pcw < n; c++) begin
      @(negedge clk);
      #1;
      if (busy) cyc++;
      if (pc_we) begin
        pcw++;
        if (pcw == n) run = 1'b0;
      end
    end
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  initial begin
    int cyc, pcw;
    int exp_st[4];
    rst_n = 1'b0; run = 1'b0;
    mem_wr = 0; reg_wr = 0; mem_to_reg = 0;
    branch_z = 0; branch_nz = 0; jmp = 0; jmp_r = 0;
    link = 0; zero = 0; imem_ready = 0; dmem_ready = 0;

    //            name    mw rw m2r bz bnz j jr lk z  iw dw cyc sel rf dq dwe
    vt[0]  = mk("ADDI",   0,1,0, 0,0, 0,0,0,0, 0,0, 4,0,1,0,0);
    vt[1]  = mk("LW",     0,1,1, 0,0, 0,0,0,0, 0,2, 7,0,1,3,0);
    vt[2]  = mk("SW",     1,0,0, 0,0, 0,0,0,0, 0,0, 4,0,0,1,1);
    vt[3]  = mk("BEQZt",  0,0,0, 1,0, 0,0,0,1, 0,0, 3,1,0,0,0);
    vt[4]  = mk("BNEZn",  0,1,0, 0,1, 0,0,0,1, 0,0, 3,0,0,0,0);
    vt[5]  = mk("BEQZn",  0,0,0, 1,0, 0,0,0,0, 0,0, 3,0,0,0,0);
    vt[6]  = mk("BNEZt",  0,0,0, 0,1, 0,0,0,0, 0,0, 3,1,0,0,0);
    vt[7]  = mk("J",      0,0,0, 0,0, 1,0,0,0, 0,0, 3,2,0,0,0);
    vt[8]  = mk("JR",     0,1,0, 0,0, 0,1,0,0, 0,0, 3,3,0,0,0);
    vt[9]  = mk("JAL",    0,0,0, 0,0, 1,0,1,0, 0,0, 4,2,1,0,0);
    vt[10] = mk("JALR",   0,0,0, 0,0, 0,1,1,0, 0,0, 4,3,1,0,0);
    vt[11] = mk("ADDIw3", 0,1,0, 0,0, 0,0,0,0, 3,0, 7,0,1,0,0);
    vt[12] = mk("SWw1",   1,0,0, 0,0, 0,0,0,0, 0,1, 5,0,0,2,2);
    vt[13] = mk("BRprio", 0,0,0, 1,0, 1,0,0,1, 0,0, 3,1,0,0,0);
    exp_st[0] = 1; exp_st[1] = 2; exp_st[2] = 3; exp_st[3] = 5;

    repeat (2) @(negedge clk);
    #1;
    chk("rst state", int'(state), 0);
    chk("rst outs", int'({imem_req, ir_we, dmem_req, dmem_we,
                          rf_we, pc_we, pc_sel, busy}), 0);
    rst_n = 1'b1;

    // Ready inputs with no request must not move anything.
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (ir_we || pc_we || busy) cyc++;
    end
    chk("idle ignores ready", cyc, 0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i]);
      if (i == 0) begin
        chk("ADDI seq len", st_n, 4);
        for (int k = 0; k < 4; k++)
          chk("ADDI state seq", st_log[k], exp_st[k]);
      end
    end

    run_addi(2, cyc, pcw);
    chk("2xADDI retired", pcw, 2);
    chk("2xADDI cycles", cyc, 8);

    // Store stalled in MEM, then reset mid-request.
    set_dec(vt[2]);
    run = 1'b1;
    imem_ready = 1'b1;
    cyc = 0;
    for (int c = 0; c < 20 && state != 3'd4; c++) begin
      @(negedge clk);
      cyc++;
    end
    imem_ready = 1'b0;
    run = 1'b0;
    #1;
    chk("SW reaches MEM", int'(state), 4);
    chk("SW dmem_req", int'(dmem_req), 1);
    chk("SW dmem_we", int'(dmem_we), 1);
    @(negedge clk);
    #1;
    chk("SW still stalled", int'(dmem_req), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst drops dmem_req", int'(dmem_req), 0);
    chk("rst mid state", int'(state), 0);
    chk("rst mid outs", int'({imem_req, ir_we, dmem_req, dmem_we,
                              rf_we, pc_we, pc_sel, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("run low stays idle", int'({state, busy}), 0);

`ifdef DLX_SEQ_PERF_EN
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("perf rst cyc", int'(cycle_cnt), 0);
    chk("perf rst ins", int'(instr_cnt), 0);
    rst_n = 1'b1;
    run_addi(10, cyc, pcw);
    chk("perf instr_cnt", int'(instr_cnt), 10);
    chk("perf cycle_cnt", int'(cycle_cnt), 40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
